// File: rtl/sap1_loader_pkg.sv
// Shared types for the SAP-1 program RAM loader.
// Frame start byte and the loader state encoding.
package sap1_loader_pkg;

  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE
  } state_t;

endpackage

// File: rtl/sap1_ram_loader.sv
// Framed byte-stream writer for the SAP-1 16x8 program RAM.
// Holds the CPU in clear while a frame loads, releases it on a good checksum.
module sap1_ram_loader #(
  parameter int         ADDR_W = 4,
  parameter int         DATA_W = 8,
  parameter logic [7:0] HEADER = sap1_loader_pkg::HEADER
) (
  input  logic              base_clock,
  input  logic              CLR_bar,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we_bar,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  import sap1_loader_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
  logic              take;
  logic              len_ok;
  logic [DATA_W-1:0] chk_sum;

  assign take    = rx_valid & rx_ready;
  assign len_ok  = (rx_data != '0) &&
                   (int'(rx_data) <= DEPTH);
  assign chk_sum = sum_q + rx_data;

  always_ff @(posedge base_clock or negedge CLR_bar) begin
    if (!CLR_bar) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_d   = sum_q;
    hold_d  = hold_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (take && rx_data == DATA_W'(HEADER)) begin
          state_d = S_LEN;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          sum_d   = '0;
        end
      end
      S_LEN: begin
        if (take) begin
          if (len_ok) begin
            state_d = S_DATA;
            cnt_d   = rx_data[ADDR_W:0];
            addr_d  = '0;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (take) begin
          state_d = S_WRITE;
          data_d  = rx_data;
          sum_d   = chk_sum;
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q - (ADDR_W+1)'(1);
        // last byte keeps its address so a full frame ends at the top word
        if (cnt_q == (ADDR_W+1)'(1)) begin
          state_d = S_CHK;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_DATA;
        end
      end
      S_CHK: begin
        if (take) begin
          if (chk_sum == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        hold_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): rx_ready = CLR_bar;
      (state_q == S_LEN):  rx_ready = CLR_bar;
      (state_q == S_DATA): rx_ready = CLR_bar;
      (state_q == S_CHK):  rx_ready = CLR_bar;
      default:             rx_ready = 1'b0;
    endcase
  end

  assign ram_we_bar = (state_q != S_WRITE);
  assign load_done  = (state_q == S_DONE);
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign cpu_hold   = hold_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_sap1_ram_loader.sv
// Bench for sap1_ram_loader: directed frames plus random frames
// checked against a frame-level model of RAM, flags and pulses.
module tb_sap1_ram_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we_bar;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] stream[$];
  logic [7:0] ram_m[16];
  logic [7:0] ref_ram[16];
  int         we_cnt = 0;
  int         done_cnt = 0;
  int         long_we = 0;
  int         long_done = 0;
  int         ovl = 0;
  logic       prev_we = 1'b0;
  logic       prev_done = 1'b0;
  logic       hold_at_done = 1'b0;
  logic       exp_err;
  logic       exp_hold;
  logic [3:0] exp_addr;

  sap1_ram_loader dut (
    .base_clock(clk),
    .CLR_bar   (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_we_bar(ram_we_bar),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!ram_we_bar) begin
      ram_m[ram_addr] = ram_data;
      we_cnt++;
      if (prev_we) long_we++;
      if (rx_ready) ovl++;
    end
    if (load_done) begin
      done_cnt++;
      hold_at_done = cpu_hold;
      if (prev_done) long_done++;
      if (rx_ready) ovl++;
    end
    prev_we   = !ram_we_bar;
    prev_done = load_done;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_stream(input bit gaps);
    int to;
    for (int i = 0; i < stream.size(); i++) begin
      @(negedge clk);
      rx_data  = stream[i];
      rx_valid = 1'b1;
      to = 0;
      while (!rx_ready && to < 50) begin
        @(negedge clk);
        to++;
      end
      chk("rx_ready_wait", 32'(to < 50), 32'd1);
      @(posedge clk);
      if (gaps) begin
        #1 rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    #1 rx_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".ready"}, 32'(rx_ready), 32'd0);
    chk({tag, ".addr"}, 32'(ram_addr), 32'd0);
    chk({tag, ".data"}, 32'(ram_data), 32'd0);
    chk({tag, ".we_bar"}, 32'(ram_we_bar), 32'd1);
    chk({tag, ".hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, ".done"}, 32'(load_done), 32'd0);
    chk({tag, ".err"}, 32'(load_err), 32'd0);
  endtask

  // hidx < 0 means the stream holds only idle junk
  task automatic run_frame(input string tag, input bit gaps,
                           input int hidx);
    int we0, d0, exp_wr, exp_done, len, s;
    we0 = we_cnt;
    d0 = done_cnt;
    exp_wr = 0;
    exp_done = 0;
    if (hidx >= 0) begin
      len = int'(stream[hidx+1]);
      exp_hold = 1'b1;
      exp_err = 1'b0;
      if (len < 1 || len > 16) begin
        exp_err = 1'b1;
      end else begin
        s = 0;
        for (int i = 0; i < len; i++) begin
          ref_ram[i] = stream[hidx+2+i];
          s += int'(stream[hidx+2+i]);
        end
        s += int'(stream[hidx+2+len]);
        exp_wr = len;
        exp_addr = 4'(len - 1);
        if ((s & 255) == 0) begin
          exp_done = 1;
          exp_hold = 1'b0;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
    send_stream(gaps);
    repeat (4) @(negedge clk);
    chk({tag, ".writes"}, 32'(we_cnt - we0), 32'(exp_wr));
    chk({tag, ".done"}, 32'(done_cnt - d0), 32'(exp_done));
    chk({tag, ".err"}, 32'(load_err), 32'(exp_err));
    chk({tag, ".hold"}, 32'(cpu_hold), 32'(exp_hold));
    chk({tag, ".addr"}, 32'(ram_addr), 32'(exp_addr));
    chk({tag, ".long_we"}, 32'(long_we), 32'd0);
    chk({tag, ".long_done"}, 32'(long_done), 32'd0);
    chk({tag, ".ready_overlap"}, 32'(ovl), 32'd0);
    if (exp_done == 1)
      chk({tag, ".hold_at_done"}, 32'(hold_at_done), 32'd1);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s.ram%0d", tag, i), 32'(ram_m[i]),
          32'(ref_ram[i]));
  endtask

  task automatic load_good1();
    stream = '{8'hA5, 8'h03, 8'h10, 8'h21, 8'hE0, 8'hEF};
  endtask

  task automatic build_random(output int hidx);
    logic [7:0] b, len;
    int r, s;
    stream.delete();
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      stream.push_back(b);
    end
    hidx = stream.size();
    r = $urandom_range(0, 9);
    if (r == 0) len = 8'h00;
    else if (r == 1) len = 8'($urandom_range(17, 255));
    else len = 8'($urandom_range(1, 16));
    stream.push_back(8'hA5);
    stream.push_back(len);
    if (len >= 1 && len <= 16) begin
      s = 0;
      for (int i = 0; i < int'(len); i++) begin
        b = 8'($urandom);
        s += int'(b);
        stream.push_back(b);
      end
      if ($urandom_range(0, 2) == 0) stream.push_back(8'($urandom));
      else stream.push_back(8'(256 - (s & 255)));
    end
  endtask

  initial begin
    int hidx;
    for (int i = 0; i < 16; i++) begin
      ram_m[i] = 8'h00;
      ref_ram[i] = 8'h00;
    end
    exp_err = 1'b0;
    exp_hold = 1'b0;
    exp_addr = 4'h0;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(rx_ready), 32'd1);

    load_good1();
    run_frame("good1", 1'b1, 0);

    stream = '{8'hA5, 8'h03, 8'h10, 8'h21, 8'hE0, 8'h00};
    run_frame("bad_chk", 1'b1, 0);
    load_good1();
    run_frame("good_after_bad", 1'b0, 0);

    stream = '{8'hA5, 8'h00};
    run_frame("len0", 1'b0, 0);
    stream = '{8'hA5, 8'h11};
    run_frame("len17", 1'b1, 0);
    stream = '{8'h3C};
    run_frame("drop3c", 1'b0, -1);

    stream = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) stream.push_back(8'(i));
    stream.push_back(8'h88);
    run_frame("full16", 1'b0, 0);

    load_good1();
    run_frame("backpressure", 1'b0, 0);

    stream = '{8'hA5, 8'h03, 8'h10, 8'h21};
    hidx = we_cnt;
    send_stream(1'b0);
    repeat (2) @(negedge clk);
    chk("midreset.writes", 32'(we_cnt - hidx), 32'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    ref_ram[0] = 8'h10;
    ref_ram[1] = 8'h21;
    exp_err = 1'b0;
    exp_hold = 1'b0;
    exp_addr = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    load_good1();
    run_frame("after_reset", 1'b0, 0);

    for (int n = 0; n < 12; n++) begin
      build_random(hidx);
      run_frame($sformatf("rand%0d", n), n[0], hidx);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
